uart_rx_param: RTL and testbench

//   Parametrised UART receiver, successor to the fixed 7-bit Hamming receiver. Configurable word

---
 rtl/uart_rx_param.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with majority-vote sampling,
// parity/framing detection and a valid/ready output holding register.
module uart_rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int OSR         = 8,
  parameter int PARITY_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [2:0]           state_out
);

  localparam int CW  = $clog2(OSR);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int MID = OSR / 2;

  localparam logic [CW-1:0] C_M0    = CW'(MID - 1);
  localparam logic [CW-1:0] C_M1    = CW'(MID);
  localparam logic [CW-1:0] C_M2    = CW'(MID + 1);
  localparam logic [CW-1:0] C_LAST  = CW'(OSR - 1);
  localparam logic [BW-1:0] C_BLAST = BW'(DATA_BITS - 1);
  localparam logic          HAS_PAR = (PARITY_MODE != 0);
  localparam logic          ODD_PAR = (PARITY_MODE == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [BW-1:0]        r_bit;
  logic [BW-1:0]        w_bit_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 r_perr;
  logic                 w_perr_nxt;
  logic                 r_s0;
  logic                 r_s1;
  logic                 w_s0_nxt;
  logic                 w_s1_nxt;
  logic                 w_maj;
  logic                 w_at_m2;
  logic                 w_at_last;
  logic                 w_commit;
  logic                 w_hs;

  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perr_o;
  logic                 r_ferr_o;
  logic                 r_ovr;

  // Synchroniser runs every clock; ena only gates the frame logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_s0    <= 1'b0;
      r_s1    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_perr  <= w_perr_nxt;
      r_s0    <= w_s0_nxt;
      r_s1    <= w_s1_nxt;
    end
  end

  assign w_maj     = (r_s0 & r_s1) | (r_s0 & r_rx_s) | (r_s1 & r_rx_s);
  assign w_at_m2   = (r_cnt == C_M2);
  assign w_at_last = (r_cnt == C_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_perr_nxt  = r_perr;
    w_s0_nxt    = r_s0;
    w_s1_nxt    = r_s1;
    w_commit    = 1'b0;
    if (ena) begin
      if (r_state != S_IDLE) begin
        w_cnt_nxt = w_at_last ? '0 : r_cnt + 1'b1;
        if (r_cnt == C_M0) w_s0_nxt = r_rx_s;
        if (r_cnt == C_M1) w_s1_nxt = r_rx_s;
      end
      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            w_state_nxt = S_START;
            w_cnt_nxt   = '0;
          end
        end
        S_START: begin
          if (w_at_m2 && w_maj) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else if (w_at_last) begin
            w_state_nxt = S_DATA;
            w_bit_nxt   = '0;
          end
        end
        S_DATA: begin
          if (w_at_m2)
            w_shift_nxt = {w_maj, r_shift[DATA_BITS-1:1]};
          if (w_at_last) begin
            if (r_bit == C_BLAST)
              w_state_nxt = HAS_PAR ? S_PARITY : S_STOP;
            else
              w_bit_nxt = r_bit + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_at_m2)
            w_perr_nxt = ODD_PAR ? ~^{r_shift, w_maj}
                                 :  ^{r_shift, w_maj};
          if (w_at_last)
            w_state_nxt = S_STOP;
        end
        S_STOP: begin
          // Leave before the stop bit ends so a back-to-back start is seen.
          if (w_at_m2) begin
            w_commit    = 1'b1;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
        end
      endcase
    end
  end

  assign w_hs = r_valid & ready_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_perr_o <= 1'b0;
      r_ferr_o <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      if (w_commit && (!r_valid || w_hs)) begin
        r_data   <= r_shift;
        r_perr_o <= HAS_PAR ? r_perr : 1'b0;
        r_ferr_o <= ~w_maj;
        r_valid  <= 1'b1;
      end else if (w_hs) begin
        r_valid  <= 1'b0;
      end
      if (w_commit && r_valid && !w_hs)
        r_ovr <= 1'b1;
      else if (w_hs)
        r_ovr <= 1'b0;
    end
  end

  assign data_out   = r_data;
  assign valid_out  = r_valid;
  assign parity_err = r_perr_o;
  assign frame_err  = r_ferr_o;
  assign overrun    = r_ovr;
  assign state_out  = r_state;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param (8 data bits, OSR 8, even parity).
// One ena tick every 4 clocks; rx is set 3.5 clocks ahead of each tick.
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       rx;
  logic       ready_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic [2:0] state_out;

  int n_chk = 0;
  int n_err = 0;

  int         cap_cnt = 0;
  int         vhi_cnt = 0;
  logic [7:0] cap_data = '0;
  logic       cap_perr = 1'b0;
  logic       cap_ferr = 1'b0;

  uart_rx_param #(
    .DATA_BITS  (8),
    .OSR        (8),
    .PARITY_MODE(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .rx        (rx),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid_out) vhi_cnt <= vhi_cnt + 1;
    if (!rst && valid_out && ready_in) begin
      cap_cnt  <= cap_cnt + 1;
      cap_data <= data_out;
      cap_perr <= parity_err;
      cap_ferr <= frame_err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_tick(input logic b);
    rx  = b;
    ena = 1'b0;
    repeat (3) @(negedge clk);
    ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par,
                            input logic stp, input int glitch,
                            input int n_ticks, output logic v_commit);
    logic [10:0] fr;
    logic        b;
    fr       = {stp, par, d, 1'b0};
    v_commit = 1'b0;
    for (int t = 0; t < n_ticks; t++) begin
      b = (t < 88) ? fr[t/8] : 1'b1;
      if (t == glitch) b = ~b;
      do_tick(b);
      if (t == 86) v_commit = valid_out;
    end
  endtask

  task automatic set_ready(input logic r);
    @(negedge clk);
    #1 ready_in = r;
  endtask

  int   c0;
  int   v0;
  logic vc;

  initial begin
    rst      = 1'b1;
    ena      = 1'b0;
    rx       = 1'b1;
    ready_in = 1'b1;
    #2;
    chk("rst_state", state_out, 3'd0);
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_flags", {parity_err, frame_err, overrun}, 3'b000);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (4) do_tick(1'b1);

    c0 = cap_cnt; v0 = vhi_cnt;
    send_frame(8'hA5, 1'b0, 1'b1, -1, 98, vc);
    chk("a5_latency", vc, 1'b1);
    chk("a5_count", cap_cnt - c0, 1);
    chk("a5_pulse", vhi_cnt - v0, 1);
    chk("a5_data", cap_data, 8'hA5);
    chk("a5_flags", {cap_perr, cap_ferr}, 2'b00);

    c0 = cap_cnt;
    send_frame(8'hA5, 1'b1, 1'b1, -1, 98, vc);
    chk("perr_count", cap_cnt - c0, 1);
    chk("perr_data", cap_data, 8'hA5);
    chk("perr_flags", {cap_perr, cap_ferr}, 2'b10);

    c0 = cap_cnt;
    send_frame(8'hA5, 1'b0, 1'b0, -1, 98, vc);
    chk("ferr_count", cap_cnt - c0, 1);
    chk("ferr_data", cap_data, 8'hA5);
    chk("ferr_flags", {cap_perr, cap_ferr}, 2'b01);
    chk("ferr_idle", state_out, 3'd0);

    c0 = cap_cnt; v0 = vhi_cnt;
    do_tick(1'b0);
    do_tick(1'b0);
    do_tick(1'b1);
    do_tick(1'b1);
    chk("fs_start", state_out, 3'd1);
    repeat (3) do_tick(1'b1);
    chk("fs_idle", state_out, 3'd0);
    repeat (10) do_tick(1'b1);
    chk("fs_novalid", vhi_cnt - v0, 0);
    chk("fs_nocap", cap_cnt - c0, 0);

    c0 = cap_cnt;
    send_frame(8'h3C, 1'b0, 1'b1, 29, 98, vc);
    chk("glitch_count", cap_cnt - c0, 1);
    chk("glitch_data", cap_data, 8'h3C);
    chk("glitch_flags", {cap_perr, cap_ferr}, 2'b00);

    set_ready(1'b0);
    send_frame(8'h11, 1'b0, 1'b1, -1, 98, vc);
    chk("ovr_first_valid", vc, 1'b1);
    chk("ovr_first_flag", overrun, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, -1, 98, vc);
    chk("ovr_valid", valid_out, 1'b1);
    chk("ovr_data", data_out, 8'h11);
    chk("ovr_flag", overrun, 1'b1);
    set_ready(1'b1);
    chk("ovr_hs_data", data_out, 8'h11);
    @(negedge clk);
    chk("ovr_hs_valid", valid_out, 1'b0);
    chk("ovr_hs_clear", overrun, 1'b0);

    set_ready(1'b0);
    send_frame(8'hC3, 1'b1, 1'b0, -1, 98, vc);
    chk("hold_valid", valid_out, 1'b1);
    chk("hold_data", data_out, 8'hC3);
    chk("hold_flags", {parity_err, frame_err}, 2'b11);
    send_frame(8'hFF, 1'b0, 1'b1, -1, 40, vc);
    chk("mid_data_state", state_out, 3'd2);
    #1 rst = 1'b1;
    #1;
    chk("arst_state", state_out, 3'd0);
    chk("arst_valid", valid_out, 1'b0);
    chk("arst_data", data_out, 8'h00);
    chk("arst_flags", {parity_err, frame_err, overrun}, 3'b000);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_hold", {valid_out, data_out, state_out}, 12'h000);
    #1 rst = 1'b0;
    ready_in = 1'b1;
    repeat (4) do_tick(1'b1);

    c0 = cap_cnt;
    send_frame(8'h5A, 1'b0, 1'b1, -1, 98, vc);
    chk("post_latency", vc, 1'b1);
    chk("post_count", cap_cnt - c0, 1);
    chk("post_data", cap_data, 8'h5A);
    chk("post_flags", {cap_perr, cap_ferr}, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
